// File: rtl/instr_issue_queue_pkg.sv
// Shared types and constants for the instruction issue queue.
package instr_issue_queue_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } queue_state_t;

  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_WIDTH = 12;
  localparam int CNT_W         = 4;

  // Both operands immediate, op 00: harmless when issued.
  localparam logic [11:0] NOP_INSTR = 12'h00C;

endpackage

// File: rtl/instr_issue_queue_sync_fifo.sv
// Synchronous FIFO storage for the issue queue; clear empties it in one cycle.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int              PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]   LAST    = PW'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == DEPTH_C);
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full && !clear;
  assign w_do_pop  = pop && !empty && !clear;
  assign dout      = r_mem[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_issue_queue.sv
// Instruction issue queue: loader fills a FIFO, a run issues prog_len entries one per cycle.
// Define OPERAND_CHECK_EN to replace operand-hazard entries by NOP and raise fault.
module instr_issue_queue
  import instr_issue_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_instr,
  output logic             in_ready,
  input  logic             start,
  input  logic [3:0]       prog_len,
  input  logic             flush,
  output logic [WIDTH-1:0] instruction,
  output logic             issue_valid,
  output logic [2:0]       issue_slot,
  output logic [3:0]       count,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [1:0]       o_dbg_state
);

  localparam logic [3:0]       DEPTH_L = 4'(DEPTH);
  localparam logic [WIDTH-1:0] NOP_W   = WIDTH'(NOP_INSTR);

  queue_state_t     r_state;
  logic [3:0]       r_len;
  logic [3:0]       r_issued;
  logic [WIDTH-1:0] r_instr;
  logic             r_valid;
  logic [2:0]       r_slot;
  logic             r_done;
  logic             r_fault;

  logic             w_full;
  logic             w_empty;
  logic [3:0]       w_count;
  logic [WIDTH-1:0] w_head;
  logic [WIDTH-1:0] w_issue;
  logic             w_hazard;
  logic             w_push;
  logic             w_pop;
  logic             w_start_ok;

  // Handshake: a push happens on any cycle where in_valid && in_ready; in_instr must be
  // stable while in_valid is high and in_ready is low. in_ready never depends on in_valid.
  assign in_ready   = reset_n && !w_full && (r_state != DONE) && !flush;
  assign w_push     = in_valid && in_ready;
  assign w_start_ok = start && (r_state == IDLE) && (prog_len != 4'd0) && (prog_len <= DEPTH_L);
  assign w_pop      = (r_state == RUN) && !w_empty && (r_issued != r_len) && !flush;

`ifdef OPERAND_CHECK_EN
  // Register operands (immediate bit clear) must name a slot already issued.
  assign w_hazard = (!w_head[3] && (w_head[10:8] >= r_issued[2:0])) ||
                    (!w_head[2] && (w_head[6:4]  >= r_issued[2:0]));
  assign w_issue  = w_hazard ? NOP_W : w_head;
`else
  assign w_hazard = 1'b0;
  assign w_issue  = w_head;
`endif

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (flush),
    .push    (w_push),
    .pop     (w_pop),
    .din     (in_instr),
    .dout    (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_len    <= '0;
      r_issued <= '0;
      r_instr  <= NOP_W;
      r_valid  <= 1'b0;
      r_slot   <= '0;
      r_done   <= 1'b0;
      r_fault  <= 1'b0;
    end else if (flush) begin
      r_state  <= IDLE;
      r_instr  <= NOP_W;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_instr <= NOP_W;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_state  <= RUN;
            r_len    <= prog_len;
            r_issued <= '0;
            r_slot   <= '0;
            r_fault  <= 1'b0;
          end
        end
        RUN: begin
          // An empty queue stalls: NOP goes out and the issued count holds.
          if (r_issued == r_len) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else if (w_pop) begin
            r_instr  <= w_issue;
            r_valid  <= 1'b1;
            r_slot   <= r_issued[2:0];
            r_issued <= r_issued + 4'd1;
            if (w_hazard) r_fault <= 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign instruction = r_instr;
  assign issue_valid = r_valid;
  assign issue_slot  = r_slot;
  assign count       = w_count;
  assign busy        = (r_state == RUN);
  assign done        = r_done;
  assign fault       = r_fault;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_instr_issue_queue.sv
// Directed plus randomized bench for instr_issue_queue against a queue-based reference model.
module tb_instr_issue_queue;
  import instr_issue_queue_pkg::*;

  localparam int          DEPTH = 8;
  localparam int          WIDTH = 12;
  localparam logic [11:0] NOP_W = NOP_INSTR;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_instr;
  logic             in_ready;
  logic             start;
  logic [3:0]       prog_len;
  logic             flush;
  logic [WIDTH-1:0] instruction;
  logic             issue_valid;
  logic [2:0]       issue_slot;
  logic [3:0]       count;
  logic             busy;
  logic             done;
  logic             fault;
  logic [1:0]       o_dbg_state;

  always #5 clock = ~clock;

  instr_issue_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .start       (start),
    .prog_len    (prog_len),
    .flush       (flush),
    .instruction (instruction),
    .issue_valid (issue_valid),
    .issue_slot  (issue_slot),
    .count       (count),
    .busy        (busy),
    .done        (done),
    .fault       (fault),
    .o_dbg_state (o_dbg_state)
  );

  // Reference model: exp_q holds queued instructions in order.
  logic [WIDTH-1:0] exp_q[$];
  bit               m_run;
  bit               m_fin;
  int               m_len;
  int               m_issued;
  logic [WIDTH-1:0] m_instr;
  logic             m_valid;
  logic [2:0]       m_slot;
  logic             m_done;
  logic             m_fault;
  bit               last_push;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    m_run    = 1'b0;
    m_fin    = 1'b0;
    m_len    = 0;
    m_issued = 0;
    m_instr  = NOP_W;
    m_valid  = 1'b0;
    m_slot   = 3'd0;
    m_done   = 1'b0;
    m_fault  = 1'b0;
  endfunction

  function automatic bit model_ready();
    return reset_n && !m_fin && (exp_q.size() < DEPTH) && !flush;
  endfunction

  function automatic void model_edge();
    bit               push;
    bit               hz;
    logic [WIDTH-1:0] e;
    int               slot;
    push      = in_valid && model_ready();
    last_push = push;
    if (!reset_n) begin
      model_reset();
      return;
    end
    if (flush) begin
      exp_q.delete();
      m_run   = 1'b0;
      m_fin   = 1'b0;
      m_instr = NOP_W;
      m_valid = 1'b0;
      m_done  = 1'b0;
      m_fault = 1'b0;
      return;
    end
    m_instr = NOP_W;
    m_valid = 1'b0;
    m_done  = 1'b0;
    if (m_fin) begin
      m_fin = 1'b0;
    end else if (m_run) begin
      if (m_issued == m_len) begin
        m_run  = 1'b0;
        m_fin  = 1'b1;
        m_done = 1'b1;
      end else if (exp_q.size() > 0) begin
        e    = exp_q.pop_front();
        slot = m_issued % 8;
`ifdef OPERAND_CHECK_EN
        hz = (!e[3] && int'(e[10:8]) >= slot) || (!e[2] && int'(e[6:4]) >= slot);
`else
        hz = 1'b0;
`endif
        m_instr = hz ? NOP_W : e;
        if (hz) m_fault = 1'b1;
        m_slot  = 3'(slot);
        m_valid = 1'b1;
        m_issued++;
      end
    end else if (start && int'(prog_len) >= 1 && int'(prog_len) <= DEPTH) begin
      m_run    = 1'b1;
      m_len    = int'(prog_len);
      m_issued = 0;
      m_slot   = 3'd0;
      m_fault  = 1'b0;
    end
    if (push) exp_q.push_back(in_instr);
  endfunction

  task automatic check_outputs(input string ph);
    queue_state_t es;
    es = m_run ? RUN : (m_fin ? DONE : IDLE);
    chk({ph, ".instruction"}, 32'(instruction), 32'(m_instr));
    chk({ph, ".issue_valid"}, 32'(issue_valid), 32'(m_valid));
    chk({ph, ".issue_slot"},  32'(issue_slot),  32'(m_slot));
    chk({ph, ".count"},       32'(count),       32'(exp_q.size()));
    chk({ph, ".busy"},        32'(busy),        32'(m_run));
    chk({ph, ".done"},        32'(done),        32'(m_done));
    chk({ph, ".fault"},       32'(fault),       32'(m_fault));
    chk({ph, ".state"},       32'(o_dbg_state), 32'(es));
  endtask

  // Inputs are driven just after a rising edge; one tick advances model and DUT together.
  task automatic tick(input string ph);
    #1;
    chk({ph, ".in_ready"}, 32'(in_ready), 32'(model_ready()));
    model_edge();
    @(posedge clock);
    #1;
    check_outputs(ph);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_instr = '0;
    start    = 1'b0;
    prog_len = 4'd0;
    flush    = 1'b0;
  endtask

  task automatic push_one(input logic [WIDTH-1:0] v, input string ph);
    in_valid = 1'b1;
    in_instr = v;
    tick(ph);
    in_valid = 1'b0;
  endtask

  task automatic start_run(input int len, input string ph);
    start    = 1'b1;
    prog_len = 4'(len);
    tick(ph);
    start    = 1'b0;
  endtask

  initial begin
    // Reset values
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    tick("reset");
    tick("reset");
    reset_n = 1'b1;
    tick("post_reset");

    // Three entries, three consecutive issues, then done
    push_one(12'h10C, "basic");
    push_one(12'h21C, "basic");
    push_one(12'h32C, "basic");
    start_run(3, "basic");
    for (int i = 0; i < 6; i++) tick("basic");
    chk("basic.count_end", 32'(count), 32'd0);

    // Full queue backpressure; ninth entry survives the run
    for (int i = 0; i < 8; i++) push_one(12'(i * 16 + 12), "full");
    in_valid = 1'b1;
    in_instr = 12'hABC;
    start_run(8, "full");
    for (int i = 0; i < 14; i++) begin
      tick("full");
      if (last_push) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk("full.leftover", 32'(count), 32'd1);
    chk("full.idle_state", 32'(o_dbg_state), 32'(IDLE));
    flush = 1'b1;
    tick("flush_idle");
    flush = 1'b0;

    // Underflow stall then late push
    start_run(2, "stall");
    for (int i = 0; i < 3; i++) tick("stall");
    push_one(12'h1DC, "stall");
    tick("stall");
    chk("stall.first_instr", 32'(instruction), 32'h1DC);
    chk("stall.first_slot", 32'(issue_slot), 32'd0);
    push_one(12'h2EC, "stall");
    for (int i = 0; i < 4; i++) tick("stall");

    // Operand hazard at slot 0
    push_one(12'h504, "hazard");
    start_run(1, "hazard");
    tick("hazard");
`ifdef OPERAND_CHECK_EN
    chk("hazard.instr", 32'(instruction), 32'h00C);
    chk("hazard.fault", 32'(fault), 32'd1);
`else
    chk("hazard.instr", 32'(instruction), 32'h504);
    chk("hazard.fault", 32'(fault), 32'd0);
`endif
    chk("hazard.valid", 32'(issue_valid), 32'd1);
    for (int i = 0; i < 3; i++) tick("hazard");

    // Flush mid-run with four entries still queued
    for (int i = 0; i < 6; i++) push_one(12'(12'h30C + i * 16), "flush");
    start_run(8, "flush");
    tick("flush");
    tick("flush");
    chk("flush.count_before", 32'(count), 32'd4);
    flush = 1'b1;
    tick("flush");
    flush = 1'b0;
    chk("flush.count_after", 32'(count), 32'd0);
    chk("flush.busy_after", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) tick("flush_post");

    // Asynchronous reset mid-run
    for (int i = 0; i < 3; i++) push_one(12'(12'h10C + i * 256), "areset");
    start_run(3, "areset");
    tick("areset");
    tick("areset");
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("areset_now");
    chk("areset_now.in_ready", 32'(in_ready), 32'd0);
    tick("areset_hold");
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) tick("areset_post");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_instr = 12'($urandom);
      start    = ($urandom_range(0, 7) == 0);
      prog_len = 4'($urandom_range(0, 10));
      flush    = ($urandom_range(0, 39) == 0);
      tick("rand");
    end
    idle_inputs();
    tick("rand_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_issue_queue.md
INSTR_ISSUE_QUEUE -- requirements
Module: instr_issue_queue

Interface
REQ-001 Parameter DEPTH, default 8, is the queue entries and the maximum program length.
REQ-002 Parameter WIDTH, default 12, is the instruction width in bits.
REQ-003 Port clock, input, 1, is the single clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1, is the asynchronous, active-low reset.
REQ-005 Port in_valid, input, 1, means the loader presents an instruction.
REQ-006 Port in_instr, input, WIDTH, is the loader instruction.
REQ-007 Port in_ready, output, 1, means the queue accepts in_instr this cycle.
REQ-008 Port start, input, 1, is a run request pulse.
REQ-009 Port prog_len, input, 4, is the number of instructions to issue, sampled with start.
REQ-010 Port flush, input, 1, is a synchronous abort.
REQ-011 Port instruction, output, WIDTH, is the registered instruction to the processor.
REQ-012 Port issue_valid, output, 1, means instruction carries a real issued entry.
REQ-013 Port issue_slot, output, 3, is the slot index of the current instruction.
REQ-014 Port count, output, 4, is the queue occupancy, 0..DEPTH.
REQ-015 Port busy, output, 1, is high in RUN.
REQ-016 Port done, output, 1, is a one-cycle pulse at run completion.
REQ-017 Port fault, output, 1, is the sticky operand-fault flag.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, DONE; reset enters IDLE.
REQ-019 A push SHALL occur when in_valid && in_ready; in_ready = (count < DEPTH) && state != DONE && !flush.
REQ-020 IDLE -> RUN SHALL occur when start && 1 <= prog_len <= DEPTH; otherwise start SHALL be ignored; prog_len SHALL be latched on the transition.
REQ-021 In RUN with count > 0, one entry SHALL be popped per cycle; the next cycle instruction = entry, issue_valid = 1, issue_slot = issued index.
REQ-022 In RUN with count == 0 (underflow), the next cycle instruction = NOP (12'h00C: both immediates, op 00), issue_valid = 0, and the issued counter SHALL NOT advance.
REQ-023 Pop latency SHALL be exactly one cycle; a push into an empty queue SHALL NOT bypass, so the earliest issue is the cycle after the push.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-025 Each pop SHALL increment issue_slot by 1, reset to 0 on IDLE -> RUN; 3-bit wrap.
REQ-026 When the issued count equals the latched prog_len, RUN -> DONE; in DONE, done = 1 for one cycle, then -> IDLE.
REQ-027 Entries beyond prog_len SHALL remain queued for the next run.
REQ-028 start in RUN or DONE SHALL be ignored.
REQ-029 flush SHALL have priority over push, pop and start: it empties the queue, forces IDLE, sets issue_valid = 0 and instruction = NOP next cycle, and clears fault.
REQ-030 Outside RUN, instruction SHALL hold NOP and issue_valid = 0.

Reset
REQ-031 While reset_n = 0: state = IDLE, queue empty, count = 0, instruction = NOP, issue_valid = 0, issue_slot = 0, busy = 0, done = 0, fault = 0, in_ready = 0.
REQ-032 reset_n asserted mid-run SHALL discard all queued entries and the run immediately, with no done pulse.

Configuration
REQ-033 With OPERAND_CHECK_EN defined, a popped entry SHALL be replaced by NOP, still counted as issued with issue_valid = 1, and set fault, if (bit3 == 0 && bits[10:8] >= issue_slot) or (bit2 == 0 && bits[6:4] >= issue_slot).
REQ-034 Without OPERAND_CHECK_EN, entries SHALL pass unmodified and fault SHALL be tied 0.
REQ-035 fault, once set, SHALL be cleared only by reset, flush, or an accepted start.

Structure
REQ-036 A shared package SHALL hold the queue_state_t enum (IDLE/RUN/DONE), the NOP constant and the default DEPTH/WIDTH.
REQ-037 Storage SHALL be one sub-module, sync_fifo (push, pop, full, empty, count), instantiated once.

Verification
REQ-038 Push 12'h10C, 12'h21C, 12'h32C; start with prog_len = 3 -> three consecutive issue_valid cycles, slots 0, 1, 2; done one cycle later; count = 0.
REQ-039 Push 8 entries -> in_ready = 0 on the 9th; start with prog_len = 8 -> in_ready = 1 after the first pop; the 9th push is accepted and remains queued after done.
REQ-040 Start with prog_len = 2 and an empty queue, push one entry 3 cycles later -> NOP with issue_valid = 0 for stall cycles; the entry issues as slot 0 one cycle after the push.
REQ-041 With OPERAND_CHECK_EN, issue 12'h504 at slot 0 (bit3 = 0, reg 5 >= 0) -> instruction = 12'h00C, fault = 1; without it, 12'h504 passes and fault = 0.
REQ-042 flush in mid-run with 4 entries queued -> next cycle count = 0, IDLE, issue_valid = 0, no done pulse; reset_n pulse mid-run -> all outputs at reset values.
